seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: DIGITS, 4, number of multiplexed digits (2..8).
REQ-002 Parameter: DIV, 50000, clocks per digit slot (>= DEAD+2).
REQ-003 Parameter: DEAD, 16, anode-off guard clocks at start of each slot (>= 1).
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: in_valid  in  1  new display value offered.
REQ-007 Port: in_ready  out  1  pending buffer empty; value accepted when in_valid && in_ready.
REQ-008 Port: in_bcd  in  4*DIGITS  packed BCD value; digit 0 in bits [3:0].
REQ-009 Port: blank_lz  in  1  leading-zero blanking enable, sampled at frame start.
REQ-010 Port: an_n  out  DIGITS  digit anode enables, active-low, one-hot-low or all high.
REQ-011 Port: seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 Port: digit_bcd  out  4  BCD code currently driven to the decoder.
REQ-013 Port: frame_start  out  1  one-cycle pulse when digit 0 slot begins.

Function
REQ-014 Slot counter cnt SHALL count 0..DIV-1 and wrap; digit index idx SHALL advance on cnt==DIV-1, wrapping DIGITS-1 -> 0.
REQ-015 an_n SHALL be registered: all ones while cnt < DEAD, otherwise bit idx low and all others high.
REQ-016 digit_bcd SHALL be registered: shown[idx] digit, or 4'hF when that digit is blanked.
REQ-017 seg_n SHALL be the combinational decode of registered digit_bcd: 0-9 standard active-low patterns, 10-15 all segments off (7'h7F).
REQ-018 Leading-zero blanking: when latched blank_lz=1, digit k (k>=1) SHALL be blanked iff all digits k..DIGITS-1 of shown are 0; digit 0 never blanked.
REQ-019 A blanked digit SHALL keep its anode high for the whole slot.
REQ-020 Handshake: on in_valid && in_ready, in_bcd SHALL be stored in pending and in_ready SHALL go low the next cycle.
REQ-021 in_valid while in_ready=0 SHALL be ignored; pending is not overwritten.
REQ-022 At the frame wrap cycle (idx DIGITS-1 -> 0), a full pending SHALL be copied to shown and blank_lz latched; in_ready SHALL be high the following cycle.
REQ-023 A value accepted on the frame-wrap cycle itself SHALL NOT be applied at that wrap; it is applied at the next wrap.
REQ-024 shown SHALL never change mid-frame (no tearing).
REQ-025 frame_start SHALL assert for exactly one cycle, the cycle after the wrap, with idx==0 and cnt==0.
REQ-026 Digit values >9 in in_bcd SHALL be accepted unchanged and display blank segments.

Reset
REQ-027 On rst=1 at a clock edge: cnt=0, idx=0, shown=0, pending empty, blank_lz latch=0, in_ready=1, an_n all ones, digit_bcd=4'hF, seg_n=7'h7F, frame_start=0.
REQ-028 Reset asserted mid-handshake or mid-frame SHALL discard pending and restart at slot 0 with the reset values above.
REQ-029 First frame_start after reset SHALL occur DIGITS*DIV cycles after reset release.

Structure
REQ-030 Shared package seg_pkg SHALL hold the blank code 4'hF, the all-off segment constant 7'h7F and the default DIGITS.
REQ-031 Segment decode SHALL be the existing sub-module bcd_to_7seg, instantiated once on digit_bcd.
REQ-032 Scan counter, idx, pending/shown registers and blanking logic SHALL stay in seg_scan_ctrl; no other sub-modules.

Verification (DIGITS=4, DIV=8, DEAD=2)
REQ-033 Reset, no input -> digits 1-3 blank only if blank_lz latched; with blank_lz=0 all digits show 0: seg_n=7'b1000000, an_n cycles 1110,1101,1011,0111, each low for 6 of 8 cycles.
REQ-034 Accept in_bcd=16'h1234 mid-frame -> in_ready low next cycle, display unchanged until wrap, then digit 0 slot shows 4 (7'b0011001), digit 3 shows 1.
REQ-035 blank_lz=1, in_bcd=16'h0050 -> digits 3,2 anodes never low, digit 1 shows 5, digit 0 shows 0.
REQ-036 Second in_valid (16'h9999) while pending full -> ignored; 16'h1234 displayed after wrap.
REQ-037 in_valid on wrap cycle -> value shown only one frame (32 cycles) later; frame_start pulse width exactly 1 cycle.
REQ-038 rst pulsed with pending full mid-frame -> all outputs at reset values next cycle, in_ready=1, shown=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller.
package seg_pkg;
    localparam logic [3:0] BLANK_CODE     = 4'hF;
    localparam logic [6:0] SEG_OFF        = 7'h7F;
    localparam int         DEFAULT_DIGITS = 4;
endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);
    always_comb begin
        seg_n = SEG_OFF;
        case (bcd)
            4'd0: seg_n = 7'b1000000;
            4'd1: seg_n = 7'b1111001;
            4'd2: seg_n = 7'b0100100;
            4'd3: seg_n = 7'b0110000;
            4'd4: seg_n = 7'b0011001;
            4'd5: seg_n = 7'b0010010;
            4'd6: seg_n = 7'b0000010;
            4'd7: seg_n = 7'b1111000;
            4'd8: seg_n = 7'b0000000;
            4'd9: seg_n = 7'b0010000;
            default: seg_n = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed display scanner: slot timing, one-deep input buffer swapped in
// only at frame boundaries, leading-zero blanking and anode guard time.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int DIV    = 50000,
    parameter int DEAD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic [3:0]            digit_bcd,
    output logic                  frame_start
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);

    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [4*DIGITS-1:0]   shown_reg, shown_next;
    logic [4*DIGITS-1:0]   pend_reg;
    logic                  pend_full_reg;
    logic                  blz_reg, blz_next;
    logic [DIGITS-1:0]     an_n_reg, an_n_next;
    logic [3:0]            digit_bcd_reg, digit_bcd_next;
    logic                  frame_start_reg;
    logic                  slot_end, wrap, accept, blank_sel;

    logic [3:0]            shown_dig [DIGITS];
    logic [DIGITS-1:0]     upper_zero;

    // upper_zero[k]: digits k..DIGITS-1 of the value about to be displayed are all zero
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        assign shown_dig[gi]  = shown_next[4*gi +: 4];
        assign upper_zero[gi] = (shown_next[4*DIGITS-1:4*gi] == '0);
    end

    assign accept = in_valid && !pend_full_reg;

    // Outputs are registered from next-state values so they line up with cnt/idx.
    always_comb begin
        slot_end   = (cnt_reg == CW'(DIV - 1));
        wrap       = slot_end && (idx_reg == IW'(DIGITS - 1));
        cnt_next   = slot_end ? '0 : cnt_reg + 1'b1;
        idx_next   = idx_reg;
        if (slot_end) begin
            idx_next = wrap ? '0 : idx_reg + 1'b1;
        end
        shown_next = (wrap && pend_full_reg) ? pend_reg : shown_reg;
        blz_next   = wrap ? blank_lz : blz_reg;
        blank_sel  = blz_next && (idx_next != '0) && upper_zero[idx_next];

        an_n_next = '1;
        if ((cnt_next >= CW'(DEAD)) && !blank_sel) begin
            an_n_next[idx_next] = 1'b0;
        end
        digit_bcd_next = blank_sel ? BLANK_CODE : shown_dig[idx_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg         <= '0;
            idx_reg         <= '0;
            shown_reg       <= '0;
            pend_reg        <= '0;
            pend_full_reg   <= 1'b0;
            blz_reg         <= 1'b0;
            an_n_reg        <= '1;
            digit_bcd_reg   <= BLANK_CODE;
            frame_start_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            shown_reg       <= shown_next;
            blz_reg         <= blz_next;
            an_n_reg        <= an_n_next;
            digit_bcd_reg   <= digit_bcd_next;
            frame_start_reg <= wrap;
            // A value accepted on the wrap cycle waits in pending for the next wrap.
            if (wrap && pend_full_reg) begin
                pend_full_reg <= 1'b0;
            end else if (accept) begin
                pend_reg      <= in_bcd;
                pend_full_reg <= 1'b1;
            end
        end
    end

    assign in_ready    = !pend_full_reg;
    assign an_n        = an_n_reg;
    assign digit_bcd   = digit_bcd_reg;
    assign frame_start = frame_start_reg;

    bcd_to_7seg u_dec (
        .bcd   (digit_bcd_reg),
        .seg_n (seg_n)
    );
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a frame-time reference model.
module tb_seg_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int DEAD   = 2;
    localparam int FRAME  = DIGITS * DIV;
    localparam logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_bcd = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic [3:0]  digit_bcd;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Reference model state: time since reset release and buffer contents.
    int          t = 0;
    bit          m_init = 1'b0;
    logic [15:0] m_shown = '0;
    logic [15:0] m_pend = '0;
    bit          m_pfull = 1'b0;
    bit          m_blz = 1'b0;

    seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bcd      (in_bcd),
        .blank_lz    (blank_lz),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .digit_bcd   (digit_bcd),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $display("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          pos, d;
        bit          bl;
        logic [3:0]  e_an, e_dig, onehot;
        logic [6:0]  e_seg;
        pos = t % DIV;
        d   = (t / DIV) % DIGITS;
        bl  = m_blz && (d >= 1) && ((m_shown >> (4 * d)) == 16'h0);
        onehot = 4'b0001 << d;
        e_an  = (pos < DEAD || bl) ? 4'hF : ~onehot;
        e_dig = (t == 0 || bl) ? 4'hF : m_shown[4*d +: 4];
        e_seg = (e_dig > 4'd9) ? 7'h7F : SEG_TAB[e_dig];
        chk("an_n", {12'h0, an_n}, {12'h0, e_an});
        chk("digit_bcd", {12'h0, digit_bcd}, {12'h0, e_dig});
        chk("seg_n", {9'h0, seg_n}, {9'h0, e_seg});
        chk("frame_start", {15'h0, frame_start}, {15'h0, (t > 0 && pos == 0 && d == 0)});
        chk("in_ready", {15'h0, in_ready}, {15'h0, !m_pfull});
    endtask

    // One clock cycle: check outputs for the current model time, drive inputs, advance model.
    task automatic cycle(input bit v, input logic [15:0] d, input bit b, input bit r);
        bit wrap;
        @(negedge clk);
        if (m_init) check_outputs();
        in_valid = v;
        in_bcd   = d;
        blank_lz = b;
        rst      = r;
        if (r) begin
            m_init  = 1'b1;
            m_shown = '0;
            m_pend  = '0;
            m_pfull = 1'b0;
            m_blz   = 1'b0;
            t       = 0;
        end else if (m_init) begin
            wrap = ((t % FRAME) == FRAME - 1);
            if (wrap && m_pfull) begin
                m_shown = m_pend;
                m_pfull = 1'b0;
            end else if (v && !m_pfull) begin
                m_pend  = d;
                m_pfull = 1'b1;
                $display("accept t=%0d bcd=%h blank_lz=%0b", t, d, b);
            end
            if (wrap) m_blz = b;
            t++;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit b);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, b, 1'b0);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        int r;
        v = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       v[4*k +: 4] = 4'd0;
            else if (r == 9) v[4*k +: 4] = 4'(10 + $urandom_range(0, 5));
            else             v[4*k +: 4] = 4'($urandom_range(1, 9));
        end
        return v;
    endfunction

    initial begin
        bit b;
        // Reset and idle frames: all digits show 0 without blanking.
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        idle(45, 1'b0);
        // Mid-frame accept, then a second offer that must be ignored.
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h9999, 1'b0, 1'b0);
        idle(50, 1'b0);
        // Leading-zero blanking.
        cycle(1'b1, 16'h0050, 1'b1, 1'b0);
        idle(80, 1'b1);
        // Offer exactly on the frame-wrap cycle.
        while ((t % FRAME) != FRAME - 1) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 16'h0042, 1'b1, 1'b0);
        idle(70, 1'b1);
        // Reset with pending full mid-frame.
        idle(5, 1'b0);
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        idle(3, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        idle(40, 1'b0);
        // Random traffic.
        b = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 40) == 0) b = ~b;
            cycle(($urandom_range(0, 5) == 0), rand_bcd(), b, ($urandom_range(0, 400) == 0));
        end
        @(negedge clk);
        check_outputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
